// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the receive checker and the 8-bit parallel
// generator: IEEE 802.3 constants, the byte-wide CRC step, the checker state
// enum and the payload/status records.
package crc32_pkg;

  localparam logic [31:0] CRC_INITIAL_VALUE = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_REMAINDER     = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY          = 32'h04C11DB7;
  localparam int          LEN_W             = 11;

  typedef enum logic {IDLE, FRAME} rx_state_e;

  typedef struct packed {
    logic       valid;
    logic       sof;
    logic       eof;
    logic [7:0] data;
  } rx_byte_t;

  typedef struct packed {
    logic             good;
    logic             crc_err;
    logic             len_err;
    logic             abort;
    logic [LEN_W-1:0] len;
  } rx_status_t;

  // MSB-first LFSR step over one byte, data bit 7 enters first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {d, 24'h0};
    for (int i = 0; i < 8; i++)
      x = x[31] ? ((x << 1) ^ CRC_POLY) : (x << 1);
    return x;
  endfunction

endpackage

// File: rtl/crc32_rx_check_if.sv
// Byte-stream bus of the CRC-32 receive checker.
//   in_*     : framed bytes from the deframer (in_eof marks the last FCS byte)
//   out_*    : payload bytes with the FCS stripped
//   status_* : end-of-frame verdict pulse plus held fields
//   crc      : running CRC register
// master drives in_*, slave is the checker.
interface crc32_rx_check_if;
  logic        in_valid;
  logic        in_sof;
  logic        in_eof;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic [7:0]  out_data;
  logic        status_valid;
  logic        status_good;
  logic        status_crc_err;
  logic        status_len_err;
  logic        status_abort;
  logic [10:0] status_len;
  logic [31:0] crc;

  modport master (
    output in_valid, in_sof, in_eof, in_data,
    input  out_valid, out_sof, out_eof, out_data,
    input  status_valid, status_good, status_crc_err, status_len_err,
    input  status_abort, status_len, crc
  );

  modport slave (
    input  in_valid, in_sof, in_eof, in_data,
    output out_valid, out_sof, out_eof, out_data,
    output status_valid, status_good, status_crc_err, status_len_err,
    output status_abort, status_len, crc
  );
endinterface

// File: rtl/crc32_rx_delay4.sv
// 4-byte shift buffer that holds back the trailing FCS.
//   push   : shift din in
//   flush  : empty the buffer; with push the buffer restarts holding din
//   oldest : byte pushed four pushes ago, meaningful when full
//   full   : four bytes held
module crc32_rx_delay4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] oldest,
  output logic       full
);
  logic [3:0][7:0] sr_q;
  logic [2:0]      fill_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else begin
      if (push) sr_q <= {sr_q[2:0], din};
      if (flush)
        fill_q <= push ? 3'd1 : 3'd0;
      else if (push && fill_q != 3'd4)
        fill_q <= fill_q + 3'd1;
    end

  assign oldest = sr_q[3];
  assign full   = (fill_q == 3'd4);
endmodule

// File: rtl/crc32_rx_check.sv
// Receive-side CRC-32 frame checker. Runs the CRC over every frame byte
// (FCS included), forwards the payload delayed by four bytes so the FCS is
// dropped, and pulses a registered status at end of frame or on abort.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of crc32_rx_check_if (in_*, out_*, status_*, crc)
//   MIN_LEN/MAX_LEN : legal frame length range in bytes, FCS included
module crc32_rx_check
  import crc32_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic            clk,
  input  logic            reset,
  crc32_rx_check_if.slave bus
);
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  rx_state_e        state_q, state_d;
  logic [31:0]      crc_q, crc_d, crc_nx, crc_st;
  logic [LEN_W-1:0] len_q, len_d, len_nx;
  logic             emitted_q, emitted_d;
  rx_byte_t         out_q, out_d;
  rx_status_t       stat_q, stat_d;
  logic             stat_v_q, stat_v_d;
  logic             push, flush, full;
  logic [7:0]       oldest;

  crc32_rx_delay4 u_dly (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .flush  (flush),
    .din    (bus.in_data),
    .oldest (oldest),
    .full   (full)
  );

  function automatic rx_status_t verdict(input logic [31:0] c, input logic [LEN_W-1:0] len,
                                         input logic abort);
    rx_status_t s;
    s.crc_err = (c != CRC_REMAINDER);
    s.len_err = (len < MIN_L) || (len > MAX_L);
    s.abort   = abort;
    s.good    = !s.crc_err && !s.len_err && !abort;
    s.len     = len;
    return s;
  endfunction

  assign crc_nx = crc32_byte(crc_q, bus.in_data);
  assign crc_st = crc32_byte(CRC_INITIAL_VALUE, bus.in_data);
  assign len_nx = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    emitted_d = emitted_q;
    out_d     = '0;
    stat_d    = stat_q;
    stat_v_d  = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_sof) begin
        // A start inside an open frame closes it as aborted; buffered bytes are lost.
        if (state_q == FRAME && !bus.in_eof) begin
          stat_v_d = 1'b1;
          stat_d   = verdict(crc_q, len_q, 1'b1);
        end
        crc_d     = crc_st;
        len_d     = LEN_W'(1);
        emitted_d = 1'b0;
        flush     = 1'b1;
        if (bus.in_eof) begin
          // Single-byte frame: its own verdict wins over any open frame's abort.
          stat_v_d = 1'b1;
          stat_d   = verdict(crc_st, LEN_W'(1), 1'b0);
          state_d  = IDLE;
        end else begin
          push    = 1'b1;
          state_d = FRAME;
        end
      end else if (state_q == FRAME) begin
        crc_d = crc_nx;
        len_d = len_nx;
        push  = !bus.in_eof;
        if (full) begin
          out_d     = '{valid: 1'b1, sof: !emitted_q, eof: bus.in_eof, data: oldest};
          emitted_d = 1'b1;
        end
        if (bus.in_eof) begin
          // The four bytes still buffered are the FCS.
          stat_v_d = 1'b1;
          stat_d   = verdict(crc_nx, len_nx, 1'b0);
          flush    = 1'b1;
          state_d  = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      crc_q     <= CRC_INITIAL_VALUE;
      len_q     <= '0;
      emitted_q <= 1'b0;
      out_q     <= '0;
      stat_q    <= '0;
      stat_v_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      emitted_q <= emitted_d;
      out_q     <= out_d;
      stat_q    <= stat_d;
      stat_v_q  <= stat_v_d;
    end

  assign bus.out_valid      = out_q.valid;
  assign bus.out_sof        = out_q.sof;
  assign bus.out_eof        = out_q.eof;
  assign bus.out_data       = out_q.data;
  assign bus.status_valid   = stat_v_q;
  assign bus.status_good    = stat_q.good;
  assign bus.status_crc_err = stat_q.crc_err;
  assign bus.status_len_err = stat_q.len_err;
  assign bus.status_abort   = stat_q.abort;
  assign bus.status_len     = stat_q.len;
  assign bus.crc            = crc_q;
endmodule

// File: tb/tb_crc32_rx_check.sv
// Bench for crc32_rx_check. Two instances see the same byte stream: one with
// MIN_LEN=5/MAX_LEN=100, one with default limits. Frames are built at frame
// level (payload + inverted CRC appended MSB first); expected payload/status
// events with their cycle stamps are derived from whole frames and compared
// against everything the monitor records.
module tb_crc32_rx_check;
  localparam int MIN_A = 5,  MAX_A = 100;
  localparam int MIN_B = 64, MAX_B = 1518;

  typedef logic [7:0] bq_t[$];
  typedef struct { int cyc; logic [7:0] d; logic sof; logic eof; } ob_t;
  typedef struct { int cyc; logic good, crc_err, len_err, abort; logic [10:0] len; logic [31:0] crc; } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc32_rx_check_if bus();
  crc32_rx_check_if bus_d();
  assign bus_d.in_valid = bus.in_valid;
  assign bus_d.in_sof   = bus.in_sof;
  assign bus_d.in_eof   = bus.in_eof;
  assign bus_d.in_data  = bus.in_data;

  crc32_rx_check #(.MIN_LEN(MIN_A), .MAX_LEN(MAX_A)) dut (.clk(clk), .reset(rst), .bus(bus));
  crc32_rx_check dut_d (.clk(clk), .reset(rst), .bus(bus_d));

  ob_t exp_o[$], obs_o[$];
  st_t exp_s[$], obs_s[$], exp_sd[$], obs_sd[$];
  bit  pend_v = 1'b0;
  st_t pend_a, pend_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Bit-serial reference: feed the frame one bit at a time through the divisor.
  function automatic logic [31:0] ref_crc(input bq_t q);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (q[i])
      for (int b = 7; b >= 0; b--) begin
        fb = c[31] ^ q[i][b];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    return c;
  endfunction

  function automatic bq_t good_frame(input int plen);
    bq_t q;
    logic [31:0] c;
    for (int i = 0; i < plen; i++) q.push_back(8'($urandom));
    c = ~ref_crc(q);
    for (int i = 3; i >= 0; i--) q.push_back(c[i*8 +: 8]);
    return q;
  endfunction

  function automatic st_t exp_st(input int c, input int n, input logic [31:0] res, input bit ab,
                                 input int mn, input int mx, input logic [31:0] crc_now);
    st_t s;
    s.cyc     = c;
    s.len     = (n > 2047) ? 11'd2047 : 11'(n);
    s.crc_err = (res != 32'hC704DD7B);
    s.len_err = (n < mn) || (n > mx);
    s.abort   = ab;
    s.good    = !s.crc_err && !s.len_err && !ab;
    s.crc     = crc_now;
    return s;
  endfunction

  function automatic st_t cap(input int c, input logic g, input logic ce, input logic le,
                              input logic ab, input logic [10:0] l, input logic [31:0] cr);
    st_t s;
    s.cyc = c; s.good = g; s.crc_err = ce; s.len_err = le; s.abort = ab; s.len = l; s.crc = cr;
    return s;
  endfunction

  always @(negedge clk)
    if (!rst) begin
      if (bus.out_valid) begin
        ob_t o;
        o.cyc = cyc; o.d = bus.out_data; o.sof = bus.out_sof; o.eof = bus.out_eof;
        obs_o.push_back(o);
      end
      if (bus.status_valid)
        obs_s.push_back(cap(cyc, bus.status_good, bus.status_crc_err, bus.status_len_err,
                            bus.status_abort, bus.status_len, bus.crc));
      if (bus_d.status_valid)
        obs_sd.push_back(cap(cyc, bus_d.status_good, bus_d.status_crc_err, bus_d.status_len_err,
                             bus_d.status_abort, bus_d.status_len, bus_d.crc));
    end

  // Returns the cycle stamp at which a registered response to this input is seen.
  task automatic drive(input bit v, input bit s, input bit e, input logic [7:0] d, output int dc);
    @(negedge clk);
    bus.in_valid = v; bus.in_sof = s; bus.in_eof = e; bus.in_data = d;
    dc = cyc + 1;
  endtask

  task automatic idle(input int k);
    int dc;
    repeat (k) drive(1'b0, 1'b0, 1'b0, 8'h00, dc);
  endtask

  // Valid bytes without a start marker outside a frame must be ignored.
  task automatic idle_junk(input int k);
    int dc;
    repeat (k) drive(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), 8'($urandom), dc);
  endtask

  task automatic send_frame(input bq_t fr, input bit close, input int gap_pct);
    int dcs[$];
    int dc, n;
    bq_t first;
    n = fr.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0 && int'($urandom_range(99)) < gap_pct) drive(1'b0, 1'b0, 1'b0, 8'($urandom), dc);
      drive(1'b1, i == 0, close && (i == n - 1), fr[i], dc);
      dcs.push_back(dc);
      if (i == 0 && pend_v) begin
        first.push_back(fr[0]);
        pend_a.cyc = dc; pend_a.crc = ref_crc(first);
        pend_b.cyc = dc; pend_b.crc = pend_a.crc;
        exp_s.push_back(pend_a);
        exp_sd.push_back(pend_b);
        pend_v = 1'b0;
      end
    end
    for (int k = 0; k + 4 < n; k++) begin
      ob_t o;
      o.cyc = dcs[k+4]; o.d = fr[k]; o.sof = (k == 0); o.eof = close && (k == n - 5);
      exp_o.push_back(o);
    end
    if (close) begin
      exp_s.push_back(exp_st(dcs[n-1], n, ref_crc(fr), 1'b0, MIN_A, MAX_A, ref_crc(fr)));
      exp_sd.push_back(exp_st(dcs[n-1], n, ref_crc(fr), 1'b0, MIN_B, MAX_B, ref_crc(fr)));
    end else begin
      pend_a = exp_st(0, n, ref_crc(fr), 1'b1, MIN_A, MAX_A, 32'h0);
      pend_b = exp_st(0, n, ref_crc(fr), 1'b1, MIN_B, MAX_B, 32'h0);
      pend_v = 1'b1;
    end
  endtask

  task automatic cmp_st(input string nm, input st_t o, input st_t e);
    chk({nm, "_cyc"}, o.cyc, e.cyc);
    chk({nm, "_good"}, o.good, e.good);
    chk({nm, "_crc_err"}, o.crc_err, e.crc_err);
    chk({nm, "_len_err"}, o.len_err, e.len_err);
    chk({nm, "_abort"}, o.abort, e.abort);
    chk({nm, "_len"}, o.len, e.len);
    chk({nm, "_crc"}, o.crc, e.crc);
  endtask

  initial begin
    bq_t fr, tv;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_status_valid", bus.status_valid, 1'b0);
    chk("rst_status_len", bus.status_len, 11'd0);
    chk("rst_crc", bus.crc, 32'hFFFFFFFF);
    rst = 1'b0;
    idle(2);

    // Known vector: "123456789" followed by its FCS.
    tv = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'hFC, 8'h89, 8'h19, 8'h18};
    send_frame(tv, 1'b1, 0);
    idle(2);
    chk("tv_crc", bus.crc, 32'hC704DD7B);
    chk("tv_good", bus.status_good, 1'b1);
    chk("tv_len", bus.status_len, 11'd13);
    chk("tv_def_len_err", bus_d.status_len_err, 1'b1);
    chk("tv_def_crc_err", bus_d.status_crc_err, 1'b0);

    tv[12] = 8'h19;
    send_frame(tv, 1'b1, 0);
    idle(2);
    chk("bad_crc_err", bus.status_crc_err, 1'b1);
    chk("bad_good", bus.status_good, 1'b0);

    fr = '{8'hA5, 8'h5A, 8'h3C};
    send_frame(fr, 1'b1, 0);
    idle(2);
    chk("short_len", bus.status_len, 11'd3);
    chk("short_len_err", bus.status_len_err, 1'b1);

    fr.delete();
    for (int i = 0; i < 10; i++) fr.push_back(8'($urandom));
    send_frame(fr, 1'b0, 0);
    send_frame(good_frame(9), 1'b1, 0);
    idle(2);
    chk("after_abort_good", bus.status_good, 1'b1);
    chk("after_abort_flag", bus.status_abort, 1'b0);

    // Back-to-back frames with no gap, then a single-byte frame.
    send_frame(good_frame(20), 1'b1, 0);
    send_frame(good_frame(6), 1'b1, 0);
    fr = '{8'h7E};
    send_frame(fr, 1'b1, 0);
    idle(1);

    for (int f = 0; f < 40; f++) begin
      bit ab;
      fr = good_frame($urandom_range(0, 60));
      if ($urandom_range(3) == 0) begin
        int j;
        j = $urandom_range(fr.size() - 1);
        fr[j] = fr[j] ^ 8'(1 << $urandom_range(7));
      end
      if ($urandom_range(5) == 0) begin
        fr.delete();
        repeat ($urandom_range(pend_v ? 2 : 1, 3)) fr.push_back(8'($urandom));
      end
      ab = ($urandom_range(4) == 0);
      send_frame(fr, !ab, $urandom_range(0, 30));
      if (!ab) idle_junk($urandom_range(0, 3));
    end
    if (pend_v) send_frame(good_frame(8), 1'b1, 0);
    idle(2);

    // Length counter saturation.
    send_frame(good_frame(2046), 1'b1, 0);
    idle(2);
    chk("long_len", bus.status_len, 11'd2047);
    chk("long_len_err", bus.status_len_err, 1'b1);

    // Reset in the middle of a frame: no status, outputs cleared.
    send_frame(good_frame(10), 1'b1, 0);
    fr = '{8'h11, 8'h22, 8'h33};
    send_frame(fr, 1'b0, 0);
    pend_v = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_status_good", bus.status_good, 1'b0);
    chk("mid_rst_status_len", bus.status_len, 11'd0);
    chk("mid_rst_status_valid", bus.status_valid, 1'b0);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_crc", bus.crc, 32'hFFFFFFFF);
    rst = 1'b0;
    send_frame(good_frame(12), 1'b1, 0);
    idle(3);
    chk("post_rst_good", bus.status_good, 1'b1);

    chk("n_out", obs_o.size(), exp_o.size());
    for (int i = 0; i < exp_o.size() && i < obs_o.size(); i++) begin
      chk($sformatf("out%0d_cyc", i), obs_o[i].cyc, exp_o[i].cyc);
      chk($sformatf("out%0d_data", i), obs_o[i].d, exp_o[i].d);
      chk($sformatf("out%0d_sof", i), obs_o[i].sof, exp_o[i].sof);
      chk($sformatf("out%0d_eof", i), obs_o[i].eof, exp_o[i].eof);
    end
    chk("n_status", obs_s.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++)
      cmp_st($sformatf("st%0d", i), obs_s[i], exp_s[i]);
    chk("n_status_def", obs_sd.size(), exp_sd.size());
    for (int i = 0; i < exp_sd.size() && i < obs_sd.size(); i++)
      cmp_st($sformatf("stdef%0d", i), obs_sd[i], exp_sd[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
